// File: rtl/dti_sock_pkg.sv
// Shared types and helpers for the DTI socket arbiter.
package dti_sock_pkg;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_t;

endpackage

// File: rtl/dti_sock_arbiter_rr_pick.sv
// Round-robin picker: first requester at or after ptr, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [N-1:0] rot;
    int           off;
    int           sum;

    // Rotating the doubled vector puts ptr at bit 0 so a plain
    // lowest-set-bit encoder gives the round-robin winner.
    always_comb begin
        rot = N'({req, req} >> ptr);
        off = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) off = k;
        end
        sum = off + int'(ptr);
        if (sum >= N) sum = sum - N;
        idx = IW'(sum);
        any = |req;
    end

endmodule

// File: rtl/dti_sock_arbiter.sv
// Packet-locking round-robin arbiter feeding one socket port
// from NUM_CH DTI channels, tagging each word with its channel.
module dti_sock_arbiter
    import dti_sock_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int W      = 32,
    localparam int CH_W   = clog2_min1(NUM_CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CH-1:0]   din_valid,
    output logic [NUM_CH-1:0]   din_ready,
    input  logic [NUM_CH*W-1:0] din_data,
    input  logic [NUM_CH-1:0]   din_eot,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic [W-1:0]        dout_data,
    output logic [CH_W-1:0]     dout_ch,
    output logic                dout_eot,
    output logic                busy
);

    arb_state_t      state, state_nxt;
    logic [CH_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [CH_W-1:0] lock_ch, lock_ch_nxt;
    logic [CH_W-1:0] pick_idx, cand;
    logic            pick_any, slot_free, xfer, cand_eot;
    logic [W-1:0]    cand_data;

    rr_pick #(
        .N  (NUM_CH),
        .IW (CH_W)
    ) u_pick (
        .req (din_valid),
        .ptr (rr_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign slot_free = !dout_valid || dout_ready;
    assign cand      = (state == LOCKED) ? lock_ch : pick_idx;
    assign cand_data = din_data[cand*W +: W];
    assign cand_eot  = din_eot[cand];
    assign xfer      = din_valid[cand] && din_ready[cand];
    assign busy      = (state == LOCKED);

    // A locked channel sees ready whenever the slot frees, valid or not.
    always_comb begin
        din_ready = '0;
        if (!rst && slot_free && (state == LOCKED || pick_any))
            din_ready[cand] = 1'b1;
    end

    always_comb begin
        state_nxt   = state;
        rr_ptr_nxt  = rr_ptr;
        lock_ch_nxt = lock_ch;
        if (xfer) begin
            if (cand_eot) begin
                state_nxt  = IDLE;
                rr_ptr_nxt = (cand == CH_W'(NUM_CH - 1)) ? '0 : cand + 1'b1;
            end else begin
                state_nxt   = LOCKED;
                lock_ch_nxt = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            lock_ch <= '0;
        end else begin
            state   <= state_nxt;
            rr_ptr  <= rr_ptr_nxt;
            lock_ch <= lock_ch_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_valid <= 1'b0;
            dout_data  <= '0;
            dout_ch    <= '0;
            dout_eot   <= 1'b0;
        end else if (xfer) begin
            dout_valid <= 1'b1;
            dout_data  <= cand_data;
            dout_ch    <= cand;
            dout_eot   <= cand_eot;
        end else if (dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dti_sock_arbiter.sv
// Scoreboard bench for dti_sock_arbiter (NUM_CH=4 and NUM_CH=3).
module tb_dti_sock_arbiter;

    typedef struct {
        logic [1:0]  ch;
        logic [31:0] d;
        logic        e;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   din_valid = '0;
    logic [3:0]   din_ready;
    logic [127:0] din_data = '0;
    logic [3:0]   din_eot = '0;
    logic         dout_valid;
    logic         dout_ready = 1'b1;
    logic [31:0]  dout_data;
    logic [1:0]   dout_ch;
    logic         dout_eot;
    logic         busy;

    logic         rst3 = 1'b1;
    logic [2:0]   v3 = '0;
    logic [2:0]   r3;
    logic [95:0]  d3 = '0;
    logic [2:0]   e3 = '0;
    logic         ov3;
    logic [31:0]  od3;
    logic [1:0]   och3;
    logic         oe3;
    logic         busy3;

    int n_chk = 0;
    int n_err = 0;

    exp_t        exp_q[$];
    logic [31:0] src_d[4][8];
    logic        src_e[4][8];
    int          src_n[4];
    int          src_h[4];

    always #5 clk = ~clk;

    dti_sock_arbiter #(.NUM_CH(4), .W(32)) dut (
        .clk(clk), .rst(rst),
        .din_valid(din_valid), .din_ready(din_ready),
        .din_data(din_data), .din_eot(din_eot),
        .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_data(dout_data), .dout_ch(dout_ch),
        .dout_eot(dout_eot), .busy(busy)
    );

    dti_sock_arbiter #(.NUM_CH(3), .W(32)) dut3 (
        .clk(clk), .rst(rst3),
        .din_valid(v3), .din_ready(r3),
        .din_data(d3), .din_eot(e3),
        .dout_valid(ov3), .dout_ready(1'b1),
        .dout_data(od3), .dout_ch(och3),
        .dout_eot(oe3), .busy(busy3)
    );

    task automatic clear_src();
        for (int i = 0; i < 4; i++) begin
            src_n[i] = 0;
            src_h[i] = 0;
        end
    endtask

    task automatic load(input int ch, input logic [31:0] d, input logic e);
        src_d[ch][src_n[ch]] = d;
        src_e[ch][src_n[ch]] = e;
        src_n[ch]++;
    endtask

    task automatic expect_word(input int ch, input logic [31:0] d, input logic e);
        exp_t x;
        x.ch = 2'(ch);
        x.d  = d;
        x.e  = e;
        exp_q.push_back(x);
    endtask

    // One clock: present source heads, score accepted output, retire taken words.
    task automatic cycle();
        logic [3:0] took;
        exp_t       x;
        for (int i = 0; i < 4; i++) begin
            din_valid[i] = src_h[i] < src_n[i];
            din_data[i*32 +: 32] = 32'h0;
            din_eot[i] = 1'b0;
            if (din_valid[i]) begin
                din_data[i*32 +: 32] = src_d[i][src_h[i]];
                din_eot[i] = src_e[i][src_h[i]];
            end
        end
        #1;
        if (dout_valid && dout_ready) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_extra: got ch=%0d data=%h, want no word",
                         dout_ch, dout_data);
            end else begin
                x = exp_q.pop_front();
                if (dout_ch !== x.ch || dout_data !== x.d || dout_eot !== x.e) begin
                    n_err++;
                    $display("FAIL sb_word: got ch=%0d data=%h eot=%b, want ch=%0d data=%h eot=%b",
                             dout_ch, dout_data, dout_eot, x.ch, x.d, x.e);
                end
            end
        end
        took = din_valid & din_ready;
        @(posedge clk);
        for (int i = 0; i < 4; i++)
            if (took[i]) src_h[i]++;
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) cycle();
        n_chk++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: got %0d words left, want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        clear_src();
        rst = 1'b1;
        dout_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            load(i, 32'h1000 + i, 1'b1);
            expect_word(i, 32'h1000 + i, 1'b1);
        end
        @(negedge clk);
        cycle();
        n_chk++;
        if (din_ready !== 4'b0000 || dout_valid !== 1'b0 || busy !== 1'b0 ||
            dout_ch !== 2'd0 || dout_data !== 32'h0 || dout_eot !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got rdy=%b v=%b busy=%b ch=%0d d=%h e=%b, want 0000 0 0 0 0 0",
                     din_ready, dout_valid, busy, dout_ch, dout_data, dout_eot);
        end
        rst = 1'b0;
        #1;
        n_chk++;
        if (din_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL reset_first_grant: got %b want 0001", din_ready);
        end
        cycle();
        n_chk++;
        if (dout_valid !== 1'b1 || dout_ch !== 2'd0) begin
            n_err++;
            $display("FAIL reset_latency: got v=%b ch=%0d want v=1 ch=0", dout_valid, dout_ch);
        end
        drain("reset");
    endtask

    task automatic test_round_robin();
        clear_src();
        load(0, 32'h2000, 1'b1);
        load(0, 32'h2004, 1'b1);
        load(1, 32'h2001, 1'b1);
        load(1, 32'h2005, 1'b1);
        load(2, 32'h2002, 1'b1);
        load(3, 32'h2003, 1'b1);
        expect_word(0, 32'h2000, 1'b1);
        expect_word(1, 32'h2001, 1'b1);
        expect_word(2, 32'h2002, 1'b1);
        expect_word(3, 32'h2003, 1'b1);
        expect_word(0, 32'h2004, 1'b1);
        expect_word(1, 32'h2005, 1'b1);
        for (int k = 0; k < 6; k++) begin
            cycle();
            n_chk++;
            if (dout_valid !== 1'b1) begin
                n_err++;
                $display("FAIL rr_throughput: cycle %0d got v=%b want 1", k, dout_valid);
            end
        end
        drain("rr");
    endtask

    task automatic test_packet_lock();
        clear_src();
        load(2, 32'h3000, 1'b0);
        load(2, 32'h3001, 1'b0);
        load(2, 32'h3002, 1'b1);
        load(0, 32'h3100, 1'b1);
        load(3, 32'h3300, 1'b1);
        expect_word(2, 32'h3000, 1'b0);
        expect_word(2, 32'h3001, 1'b0);
        expect_word(2, 32'h3002, 1'b1);
        expect_word(3, 32'h3300, 1'b1);
        expect_word(0, 32'h3100, 1'b1);
        cycle();
        n_chk++;
        if (busy !== 1'b1 || din_ready !== 4'b0100) begin
            n_err++;
            $display("FAIL lock_grant: got busy=%b rdy=%b want 1 0100", busy, din_ready);
        end
        cycle();
        n_chk++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL lock_busy2: got %b want 1", busy);
        end
        cycle();
        n_chk++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL lock_release: got %b want 0", busy);
        end
        drain("lock");
    endtask

    task automatic test_stall();
        clear_src();
        load(1, 32'hA5A5A5A5, 1'b1);
        load(1, 32'h5A5A5A5A, 1'b1);
        expect_word(1, 32'hA5A5A5A5, 1'b1);
        expect_word(1, 32'h5A5A5A5A, 1'b1);
        dout_ready = 1'b1;
        cycle();
        dout_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            n_chk++;
            if (dout_valid !== 1'b1 || dout_data !== 32'hA5A5A5A5 ||
                dout_ch !== 2'd1 || dout_eot !== 1'b1 || din_ready !== 4'b0000) begin
                n_err++;
                $display("FAIL stall_hold: got v=%b d=%h ch=%0d e=%b rdy=%b want 1 a5a5a5a5 1 1 0000",
                         dout_valid, dout_data, dout_ch, dout_eot, din_ready);
            end
        end
        dout_ready = 1'b1;
        cycle();
        n_chk++;
        if (dout_valid !== 1'b1 || dout_data !== 32'h5A5A5A5A) begin
            n_err++;
            $display("FAIL stall_resume: got v=%b d=%h want 1 5a5a5a5a", dout_valid, dout_data);
        end
        drain("stall");
    endtask

    task automatic test_reset_mid_packet();
        clear_src();
        load(1, 32'h5000, 1'b0);
        load(1, 32'h5001, 1'b0);
        load(1, 32'h5002, 1'b1);
        expect_word(1, 32'h5000, 1'b0);
        cycle();
        cycle();
        n_chk++;
        if (busy !== 1'b1 || dout_valid !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_locked: got busy=%b v=%b want 1 1", busy, dout_valid);
        end
        load(0, 32'h5100, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        n_chk++;
        if (dout_valid !== 1'b0 || busy !== 1'b0 || din_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL midrst_async: got v=%b busy=%b rdy=%b want 0 0 0000",
                     dout_valid, busy, din_ready);
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        expect_word(0, 32'h5100, 1'b1);
        expect_word(1, 32'h5002, 1'b1);
        cycle();
        n_chk++;
        if (dout_valid !== 1'b1 || dout_ch !== 2'd0) begin
            n_err++;
            $display("FAIL midrst_regrant: got v=%b ch=%0d want 1 0", dout_valid, dout_ch);
        end
        drain("midrst");
    endtask

    task automatic test_wrap3();
        @(negedge clk);
        rst3 = 1'b0;
        v3 = 3'b100;
        e3 = 3'b111;
        d3 = {32'hC2C2C2C2, 32'h0, 32'h0};
        #1;
        n_chk++;
        if (r3 !== 3'b100) begin
            n_err++;
            $display("FAIL wrap_grant2: got %b want 100", r3);
        end
        @(negedge clk);
        n_chk++;
        if (ov3 !== 1'b1 || och3 !== 2'd2 || od3 !== 32'hC2C2C2C2) begin
            n_err++;
            $display("FAIL wrap_out2: got v=%b ch=%0d d=%h want 1 2 c2c2c2c2", ov3, och3, od3);
        end
        v3 = 3'b011;
        d3 = {32'h0, 32'hC1C1C1C1, 32'hC0C0C0C0};
        #1;
        n_chk++;
        if (r3 !== 3'b001) begin
            n_err++;
            $display("FAIL wrap_grant0: got %b want 001", r3);
        end
        @(negedge clk);
        n_chk++;
        if (ov3 !== 1'b1 || och3 !== 2'd0 || od3 !== 32'hC0C0C0C0) begin
            n_err++;
            $display("FAIL wrap_out0: got v=%b ch=%0d d=%h want 1 0 c0c0c0c0", ov3, och3, od3);
        end
        v3 = 3'b000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_src();
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_stall();
        test_reset_mid_packet();
        test_wrap3();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
